ip_checksum_update_multi: RTL and testbench



---
 rtl/ip_checksum_pkg.sv | 22 ++
 rtl/ip_checksum_fold.sv | 28 ++
 rtl/ip_checksum_update_multi.sv | 159 +++++++++++++++
 tb/tb_ip_checksum_update_multi.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_checksum_pkg.sv
// Shared types, constants and the ones-complement adder used by the
// incremental checksum updater and its fold stage.
package ip_checksum_pkg;

   localparam logic [15:0] CSUM_ZERO     = 16'h0000;
   localparam logic [15:0] CSUM_NEG_ZERO = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // 16-bit ones-complement add: bit 16 of the 17-bit sum is folded back in.
   // The second add cannot carry again because s[15:0] <= 0xFFFE whenever s[16]=1.
   function automatic logic [15:0] add1c16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'd0, s[16]};
   endfunction

endpackage

// File: rtl/ip_checksum_fold.sv
// Combinational fold of FPC field substitutions into a running ~checksum:
// each enabled slot contributes ~old then +new, chained through add1c16.
module ip_checksum_fold
   import ip_checksum_pkg::*;
#(
   parameter int FPC = 2
) (
   input  logic [15:0]       acc_in,
   input  logic [16*FPC-1:0] old_fields,
   input  logic [16*FPC-1:0] new_fields,
   input  logic [FPC-1:0]    field_en,
   output logic [15:0]       acc_out
);

   logic [15:0] acc_v;

   // Ripple the accumulator through every slot of this beat in slot order.
   always_comb begin
      acc_v = acc_in;
      for (int i = 0; i < FPC; i++) begin
         if (field_en[i]) begin
            acc_v = add1c16(add1c16(acc_v, ~old_fields[16*i +: 16]), new_fields[16*i +: 16]);
         end
      end
      acc_out = acc_v;
   end

endmodule

// File: rtl/ip_checksum_update_multi.sv
// Incremental Internet-checksum updater (HC' = ~(~HC + sum(~m + m'))).
// One request at a time: IDLE accepts, ACCUM folds FIELDS_PER_CYCLE slots per
// clock for BEATS clocks, DONE holds the result until the consumer takes it.
// Handshake rule on both sides: a transfer happens on the rising edge where
// valid and ready are both 1; valid never depends on ready, and while
// resp_valid is 1 resp_csum/resp_tag do not change.
module ip_checksum_update_multi
   import ip_checksum_pkg::*;
#(
   parameter int NUM_FIELDS       = 4,
   parameter int FIELDS_PER_CYCLE = 2,
   parameter int UDP_MODE         = 0,
   parameter int TAG_W            = 8
) (
   input  logic                    clk,
   input  logic                    sreset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [15:0]             req_csum,
   input  logic [16*NUM_FIELDS-1:0] req_old_fields,
   input  logic [16*NUM_FIELDS-1:0] req_new_fields,
   input  logic [NUM_FIELDS-1:0]   req_field_en,
   input  logic [TAG_W-1:0]        req_tag,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [15:0]             resp_csum,
   output logic [TAG_W-1:0]        resp_tag
);

   localparam int FPC       = FIELDS_PER_CYCLE;
   localparam int BEATS     = (NUM_FIELDS + FPC - 1) / FPC;
   localparam int BEAT_W    = $clog2(BEATS + 1);
   localparam int PAD_SLOTS = BEATS * FPC;

   generate
      if (FIELDS_PER_CYCLE < 1 || FIELDS_PER_CYCLE > NUM_FIELDS) begin : g_bad_fpc
         $error("FIELDS_PER_CYCLE must be in 1..NUM_FIELDS");
      end
      if (TAG_W < 1) begin : g_bad_tag
         $error("TAG_W must be at least 1");
      end
      if (UDP_MODE != 0 && UDP_MODE != 1) begin : g_bad_udp
         $error("UDP_MODE must be 0 or 1");
      end
   endgenerate

   state_t                    state, state_next;
   logic [BEAT_W-1:0]         beat;
   logic [15:0]               acc, acc_next;
   logic [15:0]               csum_q;
   logic [16*NUM_FIELDS-1:0]  old_q, new_q;
   logic [NUM_FIELDS-1:0]     en_q;
   logic [TAG_W-1:0]          tag_q;
   logic [16*PAD_SLOTS-1:0]   old_pad, new_pad;
   logic [PAD_SLOTS-1:0]      en_pad;
   logic [16*FPC-1:0]         old_sel, new_sel;
   logic [FPC-1:0]            en_sel;
   logic [15:0]               res_raw, res_final;
   logic                      accept, last_beat;

   // State register.
   always_ff @(posedge clk) begin
      if (sreset) state <= IDLE;
      else        state <= state_next;
   end

   // Next state and handshake outputs; reset forces both sides quiet.
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = !sreset;
            if (req_valid) state_next = ACCUM;
         end
         ACCUM: begin
            if (last_beat) state_next = DONE;
         end
         DONE: begin
            resp_valid = !sreset;
            if (resp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign accept    = req_valid && req_ready;
   assign last_beat = (beat == BEAT_W'(BEATS - 1));

   // Pad slot arrays to a whole number of beats; padding slots stay disabled.
   always_comb begin
      old_pad = '0;
      new_pad = '0;
      en_pad  = '0;
      old_pad[16*NUM_FIELDS-1:0] = old_q;
      new_pad[16*NUM_FIELDS-1:0] = new_q;
      en_pad[NUM_FIELDS-1:0]     = en_q;
   end

   // Slot mux: pick the FPC slots belonging to the current beat.
   always_comb begin
      old_sel = old_pad[int'(beat)*16*FPC +: 16*FPC];
      new_sel = new_pad[int'(beat)*16*FPC +: 16*FPC];
      en_sel  = en_pad[int'(beat)*FPC +: FPC];
   end

   ip_checksum_fold #(.FPC(FPC)) u_fold (
      .acc_in     (acc),
      .old_fields (old_sel),
      .new_fields (new_sel),
      .field_en   (en_sel),
      .acc_out    (acc_next)
   );

   // Final complement plus UDP zero-checksum handling.
   always_comb begin
      res_raw   = ~acc_next;
      res_final = res_raw;
      if (UDP_MODE == 1) begin
         if (csum_q == CSUM_ZERO)     res_final = CSUM_ZERO;
         else if (res_raw == CSUM_ZERO) res_final = CSUM_NEG_ZERO;
      end
   end

   // Operand capture, beat accumulation and result registers.
   always_ff @(posedge clk) begin
      if (sreset) begin
         beat      <= '0;
         acc       <= '0;
         csum_q    <= '0;
         old_q     <= '0;
         new_q     <= '0;
         en_q      <= '0;
         tag_q     <= '0;
         resp_csum <= CSUM_ZERO;
         resp_tag  <= '0;
      end else begin
         if (accept) begin
            old_q  <= req_old_fields;
            new_q  <= req_new_fields;
            en_q   <= req_field_en;
            tag_q  <= req_tag;
            csum_q <= req_csum;
            acc    <= ~req_csum;
            beat   <= '0;
         end
         if (state == ACCUM) begin
            acc  <= acc_next;
            beat <= beat + 1'b1;
            if (last_beat) begin
               resp_csum <= res_final;
               resp_tag  <= tag_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_ip_checksum_update_multi.sv
// Bench for ip_checksum_update_multi: six parameter sets share one request bus;
// sel chooses which instance is being exercised.
module tb_ip_checksum_update_multi;

   localparam int NINST = 6;

   function automatic int cfg_nf(input int k);
      case (k)
         0: return 4;
         1: return 1;
         2: return 1;
         3: return 3;
         4: return 8;
         default: return 8;
      endcase
   endfunction

   function automatic int cfg_fpc(input int k);
      case (k)
         0: return 2;
         1: return 1;
         2: return 1;
         3: return 2;
         4: return 3;
         default: return 8;
      endcase
   endfunction

   function automatic int cfg_udp(input int k);
      return (k == 2 || k == 4) ? 1 : 0;
   endfunction

   function automatic int cfg_beats(input int k);
      return (cfg_nf(k) + cfg_fpc(k) - 1) / cfg_fpc(k);
   endfunction

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic sreset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- DUT signals ----------------
   logic         req_valid;
   logic         resp_ready;
   int           sel;
   logic [15:0]  csum_in;
   logic [127:0] old_bus, new_bus;
   logic [7:0]   en_bus, tag_in;
   logic         rdy_a  [NINST];
   logic         vld_a  [NINST];
   logic [15:0]  rcsum_a[NINST];
   logic [7:0]   rtag_a [NINST];

   for (genvar g = 0; g < NINST; g++) begin : g_dut
      ip_checksum_update_multi #(
         .NUM_FIELDS       (cfg_nf(g)),
         .FIELDS_PER_CYCLE (cfg_fpc(g)),
         .UDP_MODE         (cfg_udp(g)),
         .TAG_W            (8)
      ) u_dut (
         .clk            (clk),
         .sreset         (sreset),
         .req_valid      (req_valid && (sel == g)),
         .req_ready      (rdy_a[g]),
         .req_csum       (csum_in),
         .req_old_fields (old_bus[16*cfg_nf(g)-1:0]),
         .req_new_fields (new_bus[16*cfg_nf(g)-1:0]),
         .req_field_en   (en_bus[cfg_nf(g)-1:0]),
         .req_tag        (tag_in),
         .resp_valid     (vld_a[g]),
         .resp_ready     (resp_ready),
         .resp_csum      (rcsum_a[g]),
         .resp_tag       (rtag_a[g])
      );
   end

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;
   logic [23:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: sum everything in 32 bits, fold carries once at the end.
   function automatic logic [15:0] model(input logic [15:0] hc, input logic [127:0] o,
                                         input logic [127:0] n, input logic [7:0] en,
                                         input int nf, input int udp);
      logic [31:0] s;
      logic [15:0] r;
      logic [15:0] ov, nv;
      s = {16'h0, ~hc};
      for (int i = 0; i < nf; i++) begin
         if (en[i]) begin
            ov = o[16*i +: 16];
            nv = n[16*i +: 16];
            s  = s + {16'h0, ~ov} + {16'h0, nv};
         end
      end
      while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
      r = ~s[15:0];
      if (udp != 0) begin
         if (hc == 16'h0000) r = 16'h0000;
         else if (r == 16'h0000) r = 16'hFFFF;
      end
      return r;
   endfunction

   // Scoreboard: every accepted response is compared with the oldest expectation.
   always @(negedge clk) begin
      if (!sreset) begin
         if (rdy_a[sel] && vld_a[sel]) check("ready_valid_excl", 32'd1, 32'd0);
         if (vld_a[sel] && resp_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_resp", 32'd1, 32'd0);
            end else begin
               logic [23:0] e;
               e = exp_q.pop_front();
               check("resp", {8'h0, rtag_a[sel], rcsum_a[sel]}, {8'h0, e});
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   logic [7:0] tag_ctr = 8'h00;

   task automatic send(input logic [15:0] hc, input logic [127:0] o, input logic [127:0] n,
                       input logic [7:0] en, input logic [7:0] tag, input bit push,
                       input logic [15:0] exp);
      int w;
      csum_in   = hc;
      old_bus   = o;
      new_bus   = n;
      en_bus    = en;
      tag_in    = tag;
      req_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!rdy_a[sel] && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!rdy_a[sel]) begin
         check("req_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      if (push) exp_q.push_back({tag, exp});
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      csum_in   = 16'($urandom);
      old_bus   = {$urandom, $urandom, $urandom, $urandom};
      new_bus   = {$urandom, $urandom, $urandom, $urandom};
      en_bus    = 8'($urandom);
      tag_in    = 8'($urandom);
   endtask

   task automatic send_rand(input int mode);
      logic [15:0]  hc;
      logic [127:0] o, n;
      logic [7:0]   en;
      hc = 16'($urandom);
      if (cfg_udp(sel) != 0 && $urandom_range(0, 3) == 0) hc = 16'h0000;
      o = {$urandom, $urandom, $urandom, $urandom};
      n = {$urandom, $urandom, $urandom, $urandom};
      case (mode)
         0: en = 8'h00;
         1: en = 8'hFF;
         default: en = 8'($urandom);
      endcase
      tag_ctr = tag_ctr + 8'd1;
      send(hc, o, n, en, tag_ctr, 1'b1, model(hc, o, n, en, cfg_nf(sel), cfg_udp(sel)));
   endtask

   task automatic wait_resp(input int exp_lat);
      int n;
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         n++;
         if (vld_a[sel]) break;
      end
      check("latency", n, exp_lat);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 2000) begin
         @(posedge clk);
         w++;
      end
      check("drain", exp_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] c0;
      logic [7:0]  t0;
      int w;
      sreset     = 1'b1;
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      sel        = 0;
      csum_in    = '0;
      old_bus    = '0;
      new_bus    = '0;
      en_bus     = '0;
      tag_in     = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < NINST; k++) check("rst_ready", rdy_a[k], 0);
      check("rst_valid", vld_a[0], 0);
      check("rst_csum", rcsum_a[0], 0);
      check("rst_tag", rtag_a[0], 0);
      @(posedge clk);
      #1;
      sreset = 1'b0;
      @(negedge clk);
      check("ready_after_rst", rdy_a[0], 1);
      @(posedge clk);
      #1;

      // TTL decrement, single field
      sel = 1;
      send(16'hB861, 128'h4006, 128'h3F06, 8'h01, 8'h5A, 1'b1, 16'hB961);
      wait_resp(2);
      // RFC-1624 case yields zero in plain mode
      send(16'hDD2F, 128'h5555, 128'h3285, 8'h01, 8'h11, 1'b1, 16'h0000);
      wait_resp(2);
      drain();

      // UDP mode: computed zero becomes 0xFFFF; disabled checksum stays 0
      sel = 2;
      send(16'hDD2F, 128'h5555, 128'h3285, 8'h01, 8'h22, 1'b1, 16'hFFFF);
      wait_resp(2);
      send(16'h0000, 128'h9876, 128'h0123, 8'h01, 8'h23, 1'b1, 16'h0000);
      wait_resp(2);
      drain();

      // Multi-beat: slot0 TTL, slot2 unchanged value, slots 1/3 off
      sel = 0;
      send(16'hB861, {64'h0, 16'h0000, 16'h1234, 16'hABCD, 16'h4006},
           {64'h0, 16'h0000, 16'h1234, 16'hABCD, 16'h3F06}, 8'h05, 8'h31, 1'b1, 16'hB961);
      wait_resp(3);
      send(16'hB861, {64'h0, 16'h0000, 16'h1234, 16'hABCD, 16'h4006},
           {64'h0, 16'h0000, 16'h1234, 16'hABCD, 16'h3F06}, 8'h07, 8'h32, 1'b1, 16'hB961);
      wait_resp(3);
      send(16'h1234, {$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom}, 8'h00, 8'h33, 1'b1, 16'h1234);
      wait_resp(3);
      drain();

      // Backpressure: outputs frozen while resp_ready is low
      resp_ready = 1'b0;
      send_rand(2);
      w = 0;
      while (!vld_a[0] && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("bp_rise", vld_a[0], 1);
      c0 = rcsum_a[0];
      t0 = rtag_a[0];
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_valid", vld_a[0], 1);
         check("bp_csum", rcsum_a[0], c0);
         check("bp_tag", rtag_a[0], t0);
         check("bp_ready", rdy_a[0], 0);
      end
      @(posedge clk);
      #1;
      resp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("ready_after_resp", rdy_a[0], 1);
      check("valid_after_resp", vld_a[0], 0);
      drain();

      // Reset during ACCUM discards the request
      send(16'hB861, 128'h4006, 128'h3F06, 8'h01, 8'h77, 1'b0, 16'h0000);
      sreset = 1'b1;
      @(posedge clk);
      #1;
      sreset = 1'b0;
      @(negedge clk);
      check("midrst_csum", rcsum_a[0], 0);
      check("midrst_tag", rtag_a[0], 0);
      check("midrst_ready", rdy_a[0], 1);
      for (int i = 0; i < 6; i++) begin
         check("midrst_no_resp", vld_a[0], 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      send_rand(2);
      wait_resp(3);

      // Back-to-back random requests
      for (int i = 0; i < 20; i++) send_rand(2);
      drain();

      // Sweep over parameter sets: all-off, all-on, then random enables
      for (int s = 1; s < NINST; s++) begin
         sel = s;
         send_rand(0);
         wait_resp(cfg_beats(s) + 1);
         send_rand(1);
         wait_resp(cfg_beats(s) + 1);
         for (int i = 0; i < 20; i++) send_rand(2);
         drain();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
